adc9826_cfg: RTL and testbench

Serial-port configuration sequencer for the AD9826 front end. After `cfg_start_in` it writes the four operating registers over the 3-wire SCLK/SLOAD/SDATA interface, reads each one back, and compares the result. It then raises `cfg_done_out`, which gates the capture path, and reports any read-back mismatch on `cfg_err_out`. It sits between system bring-up control and the ADC pins, and runs in the same clock domain as the capture logic.

---
 rtl/adc9826_cfg.sv | 238 +++++++++++++++++++++++
 tb/tb_adc9826_cfg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc9826_cfg.sv
// AD9826 serial-port configuration sequencer.
// Writes the four operating registers over SCLK/SLOAD/SDATA, reads each back,
// compares against the programmed values, then raises cfg_done_out.
module adc9826_cfg #(
  parameter int unsigned CLK_DIV        = 4,
  parameter logic [8:0]  REG_CFG_VAL    = 9'h058,
  parameter logic [8:0]  MUX_CFG_VAL    = 9'h0C0,
  parameter logic [8:0]  RED_PGA_VAL    = 9'h000,
  parameter logic [8:0]  RED_OFFSET_VAL = 9'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start_in,
  output logic        sclk_o,
  output logic        sload_o,
  output logic        sdata_o,
  output logic        sdata_oe,
  input  logic        sdata_in,
  output logic        cfg_busy_out,
  output logic        cfg_done_out,
  output logic        cfg_err_out,
  output logic [35:0] rdback_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StGap,
    StDone
  } state_e;

  // Last value of the phase counter; one SCLK half-period is CLK_DIV cycles.
  localparam logic [7:0] PhMax = 8'(CLK_DIV - 1);

  // Register address for each of the four slots in the sequence.
  function automatic logic [2:0] slot_addr(input logic [1:0] slot);
    logic [2:0] a;
    unique case (slot)
      2'd0:    a = 3'd0;
      2'd1:    a = 3'd1;
      2'd2:    a = 3'd2;
      default: a = 3'd5;
    endcase
    return a;
  endfunction

  // Programmed data for each slot; also the read-back reference.
  function automatic logic [8:0] slot_val(input logic [1:0] slot);
    logic [8:0] v;
    unique case (slot)
      2'd0:    v = REG_CFG_VAL;
      2'd1:    v = MUX_CFG_VAL;
      2'd2:    v = RED_PGA_VAL;
      default: v = RED_OFFSET_VAL;
    endcase
    return v;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  ph_q, ph_d;
  logic        hi_q, hi_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  frame_q, frame_d;
  logic [15:0] sr_q, sr_d;
  logic [8:0]  rx_q, rx_d;

  logic        sclk_q, sclk_d;
  logic        sload_q, sload_d;
  logic        sdata_q, sdata_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [35:0] rdback_q, rdback_d;

  logic        is_read;

  // frame_q[2] set means frames 4..7, the read-back half of the sequence.
  assign is_read = frame_q[2];

  // Next-state logic for the sequencer, counters and registered pin values.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    hi_d     = hi_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    rdback_d = rdback_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_start_in) begin
          state_d  = StLoad;
          frame_d  = 3'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          rdback_d = '0;
        end
      end

      StLoad: begin
        // Read frames carry zero data; the ADC drives those bits.
        sr_d    = {is_read, slot_addr(frame_q[1:0]), 3'b000,
                   is_read ? 9'h000 : slot_val(frame_q[1:0])};
        bit_d   = 4'd15;
        ph_d    = 8'd0;
        hi_d    = 1'b0;
        rx_d    = '0;
        state_d = StShift;
      end

      StShift: begin
        if (ph_q == PhMax) begin
          ph_d = 8'd0;
          if (hi_q) begin
            hi_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = StGap;
            end else begin
              bit_d = bit_q - 4'd1;
              sr_d  = {sr_q[14:0], 1'b0};
            end
          end else begin
            hi_d = 1'b1;
            // Sample on the same edge that raises SCLK.
            if (is_read && (bit_q <= 4'd8)) begin
              rx_d = {rx_q[7:0], sdata_in};
            end
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      StGap: begin
        // First gap cycle: commit the read-back and compare.
        if (is_read && (ph_q == 8'd0) && !hi_q) begin
          unique case (frame_q[1:0])
            2'd0:    rdback_d[8:0]   = rx_q;
            2'd1:    rdback_d[17:9]  = rx_q;
            2'd2:    rdback_d[26:18] = rx_q;
            default: rdback_d[35:27] = rx_q;
          endcase
          if (rx_q != slot_val(frame_q[1:0])) begin
            err_d = 1'b1;
          end
        end
        // Gap is two half-periods long; hi_q marks the second one.
        if (ph_q == PhMax) begin
          ph_d = 8'd0;
          if (hi_q) begin
            hi_d = 1'b0;
            if (frame_q == 3'd7) begin
              state_d = StDone;
            end else begin
              frame_d = frame_q + 3'd1;
              state_d = StLoad;
            end
          end else begin
            hi_d = 1'b1;
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Pin values follow the next state so they stay registered yet in step.
    sload_d = (state_d != StShift);
    sclk_d  = (state_d == StShift) && hi_d;
    sdata_d = (state_d == StShift) ? sr_d[15] : 1'b0;
    oe_d    = (state_d == StShift) && (!frame_d[2] || (bit_d >= 4'd9));
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ph_q     <= 8'd0;
      hi_q     <= 1'b0;
      bit_q    <= 4'd15;
      frame_q  <= 3'd0;
      sr_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      sload_q  <= 1'b1;
      sdata_q  <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdback_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      hi_q     <= hi_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      sload_q  <= sload_d;
      sdata_q  <= sdata_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdback_q <= rdback_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign sload_o      = sload_q;
  assign sdata_o      = sdata_q;
  assign sdata_oe     = oe_q;
  assign cfg_busy_out = busy_q;
  assign cfg_done_out = done_q;
  assign cfg_err_out  = err_q;
  assign rdback_o     = rdback_q;

endmodule

// File: tb/tb_adc9826_cfg.sv
// Bench for adc9826_cfg: two instances (CLK_DIV 4 and 2) with an echoing AD9826 model.
module tb_adc9826_cfg;

  logic        clk     = 1'b0;
  logic [1:0]  rst_w   = 2'b11;
  logic [1:0]  start_w = 2'b00;
  logic [1:0]  sdin_w  = 2'b00;
  wire  [1:0]  sclk_w, sload_w, sdata_w, oe_w, busy_w, done_w, err_w;
  wire  [35:0] rdb0, rdb1;

  always #5 clk = ~clk;

  adc9826_cfg #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst_w[0]), .cfg_start_in(start_w[0]),
    .sclk_o(sclk_w[0]), .sload_o(sload_w[0]), .sdata_o(sdata_w[0]), .sdata_oe(oe_w[0]),
    .sdata_in(sdin_w[0]), .cfg_busy_out(busy_w[0]), .cfg_done_out(done_w[0]),
    .cfg_err_out(err_w[0]), .rdback_o(rdb0)
  );

  adc9826_cfg #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst_w[1]), .cfg_start_in(start_w[1]),
    .sclk_o(sclk_w[1]), .sload_o(sload_w[1]), .sdata_o(sdata_w[1]), .sdata_oe(oe_w[1]),
    .sdata_in(sdin_w[1]), .cfg_busy_out(busy_w[1]), .cfg_done_out(done_w[1]),
    .cfg_err_out(err_w[1]), .rdback_o(rdb1)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  bit corrupt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_frame(input int f);
    logic [2:0] a;
    logic [8:0] v;
    case (f % 4)
      0:       begin a = 3'd0; v = 9'h058; end
      1:       begin a = 3'd1; v = 9'h0C0; end
      2:       begin a = 3'd2; v = 9'h000; end
      default: begin a = 3'd5; v = 9'h000; end
    endcase
    return {(f >= 4), a, 3'b000, (f >= 4) ? 9'h000 : v};
  endfunction

  // AD9826 model: latches SDATA on SCLK rise, echoes written registers on reads.
  int          bcnt[2];
  logic [15:0] bsr[2];
  logic [2:0]  baddr[2];
  logic [8:0]  mem[2][8];
  logic [1:0]  brw = 2'b00, boe_bad = 2'b00, pv_sclk = 2'b00, pv_sload = 2'b11;
  logic [8:0]  rv;
  logic        exp_oe;
  logic [15:0] efr;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!sload_w[i] && pv_sload[i]) begin
        bcnt[i] = 0;
        bsr[i] = '0;
        boe_bad[i] = 1'b0;
      end
      if (!sload_w[i] && sclk_w[i] && !pv_sclk[i]) begin
        if (bcnt[i] == 0) brw[i] = sdata_w[i];
        exp_oe = (bcnt[i] == 0) || !brw[i] || (bcnt[i] < 7);
        if (oe_w[i] !== exp_oe) boe_bad[i] = 1'b1;
        bsr[i] = {bsr[i][14:0], sdata_w[i]};
        bcnt[i]++;
        if (bcnt[i] == 4) baddr[i] = bsr[i][2:0];
        if (brw[i] && bcnt[i] >= 7 && bcnt[i] <= 15) begin
          rv = mem[i][baddr[i]] ^ ((corrupt && baddr[i] == 3'd1) ? 9'h001 : 9'h000);
          sdin_w[i] = rv[4'(15 - bcnt[i])];
        end
      end
      if (sload_w[i] && !pv_sload[i]) begin
        sdin_w[i] = 1'b0;
        if (bcnt[i] == 16) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame %h expected none", bsr[i]);
          end else begin
            efr = exp_q.pop_front();
            if (efr[15]) begin
              chk("rd_frame_hdr", 64'(bsr[i][15:9]), 64'(efr[15:9]));
            end else begin
              chk("wr_frame", 64'(bsr[i]), 64'(efr));
              mem[i][bsr[i][14:12]] = bsr[i][8:0];
            end
            chk("frame_oe", 64'(boe_bad[i]), 64'd0);
          end
        end
      end
      pv_sclk[i]  = sclk_w[i];
      pv_sload[i] = sload_w[i];
    end
  end

  function automatic logic [35:0] rdb(input int sel);
    return (sel != 0) ? rdb1 : rdb0;
  endfunction

  // One full sequence on instance sel with cycle-accurate checks.
  task automatic run_seq(input int sel, input bit corr, input bit mid, input int exp_done,
                         input bit exp_err, input logic [35:0] exp_rdb);
    int d, f, cyc, done_cyc, e5;
    d = (sel != 0) ? 2 : 4;
    f = 34 * d + 1;
    e5 = 5 * f + 32 * d + 1;
    corrupt = corr;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_frame(k));
    @(negedge clk);
    start_w[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_w[sel] = 1'b0;
    cyc = 0;
    done_cyc = -1;
    while (cyc < 3000 && done_cyc < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk("c1_sload", 64'(sload_w[sel]), 64'd0);
        chk("c1_busy", 64'(busy_w[sel]), 64'd1);
        chk("c1_done_clr", 64'(done_w[sel]), 64'd0);
        chk("c1_err_clr", 64'(err_w[sel]), 64'd0);
        chk("c1_rdb_clr", 64'(rdb(sel)), 64'd0);
      end
      if (mid && cyc == 3 * f + 20) start_w[sel] = 1'b1;
      if (mid && cyc == 3 * f + 21) start_w[sel] = 1'b0;
      if (cyc == e5) chk("err_before_f5", 64'(err_w[sel]), 64'd0);
      if (cyc == e5 + 1) chk("err_after_f5", 64'(err_w[sel]), 64'(exp_err));
      if (cyc == exp_done - 1) chk("busy_pre_done", 64'(busy_w[sel]), 64'd1);
      if (done_w[sel]) done_cyc = cyc;
    end
    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("busy_at_done", 64'(busy_w[sel]), 64'd0);
    chk("err_final", 64'(err_w[sel]), 64'(exp_err));
    chk("rdback", 64'(rdb(sel)), 64'(exp_rdb));
    chk("frames_left", 64'(exp_q.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_level", 64'(done_w[sel]), 64'd1);
  endtask

  typedef struct {
    int          sel;
    bit          corr;
    bit          mid;
    int          done_cyc;
    bit          err;
    logic [35:0] rdb;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++) mem[i][a] = 9'h1FF;

    tbl[0] = '{sel: 0, corr: 1'b0, mid: 1'b0, done_cyc: 1097, err: 1'b0,
               rdb: {9'h000, 9'h000, 9'h0C0, 9'h058}};
    tbl[1] = '{sel: 0, corr: 1'b1, mid: 1'b0, done_cyc: 1097, err: 1'b1,
               rdb: {9'h000, 9'h000, 9'h0C1, 9'h058}};
    tbl[2] = '{sel: 0, corr: 1'b0, mid: 1'b1, done_cyc: 1097, err: 1'b0,
               rdb: {9'h000, 9'h000, 9'h0C0, 9'h058}};
    tbl[3] = '{sel: 1, corr: 1'b0, mid: 1'b0, done_cyc: 553, err: 1'b0,
               rdb: {9'h000, 9'h000, 9'h0C0, 9'h058}};

    // Reset values on both instances.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", 64'(sclk_w), 64'd0);
    chk("rst_sload", 64'(sload_w), 64'd3);
    chk("rst_sdata", 64'(sdata_w), 64'd0);
    chk("rst_oe", 64'(oe_w), 64'd0);
    chk("rst_busy", 64'(busy_w), 64'd0);
    chk("rst_done", 64'(done_w), 64'd0);
    chk("rst_err", 64'(err_w), 64'd0);
    chk("rst_rdb", 64'(rdb0 | rdb1), 64'd0);
    @(negedge clk);
    rst_w = 2'b00;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      run_seq(tbl[v].sel, tbl[v].corr, tbl[v].mid, tbl[v].done_cyc, tbl[v].err, tbl[v].rdb);
    end

    // Reset during frame 2, bit 7 low phase (cycle 2F+1+8*2*CLK_DIV+2 = 341).
    corrupt = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_frame(k));
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (341) @(posedge clk);
    #1;
    chk("mid_sload_low", 64'(sload_w[0]), 64'd0);
    chk("mid_busy", 64'(busy_w[0]), 64'd1);
    rst_w[0] = 1'b1;
    #1;
    chk("arst_sload", 64'(sload_w[0]), 64'd1);
    chk("arst_sclk", 64'(sclk_w[0]), 64'd0);
    chk("arst_busy", 64'(busy_w[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_next_sload", 64'(sload_w[0]), 64'd1);
    chk("rst_next_oe", 64'(oe_w[0]), 64'd0);
    @(negedge clk);
    rst_w[0] = 1'b0;
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("no_restart_sload", 64'(sload_w[0]), 64'd1);
    chk("no_restart_busy", 64'(busy_w[0]), 64'd0);
    chk("no_restart_done", 64'(done_w[0]), 64'd0);
    run_seq(0, 1'b0, 1'b0, 1097, 1'b0, {9'h000, 9'h000, 9'h0C0, 9'h058});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
